// File: rtl/id_pkg.sv
// Shared decode definitions for the RV32/RV64 instruction decode stage:
// opcode and func3 constants, memory access size codes and the decoded bundle.
// With ID_ILLEGAL_TRAP_EN defined the bundle also carries an illegal flag.
package id_pkg;

  // Internal bundle fields are always 64 bits; the stage truncates to XLEN.
  localparam int MAX_XLEN = 64;

  // Major opcodes
  localparam logic [6:0] TYPE_I    = 7'b0010011;
  localparam logic [6:0] TYPE_R_M  = 7'b0110011;
  localparam logic [6:0] OP_IMM_32 = 7'b0011011;
  localparam logic [6:0] OP_32     = 7'b0111011;
  localparam logic [6:0] LOAD      = 7'b0000011;
  localparam logic [6:0] STORE     = 7'b0100011;
  localparam logic [6:0] B         = 7'b1100011;
  localparam logic [6:0] JAL       = 7'b1101111;
  localparam logic [6:0] JALR      = 7'b1100111;
  localparam logic [6:0] LUI       = 7'b0110111;
  localparam logic [6:0] AUIPC     = 7'b0010111;

  // func3 values
  localparam logic [2:0] F3_ADD_SUB = 3'b000;
  localparam logic [2:0] F3_SLL     = 3'b001;
  localparam logic [2:0] F3_SRL_SRA = 3'b101;
  localparam logic [2:0] F3_LB      = 3'b000;
  localparam logic [2:0] F3_LH      = 3'b001;
  localparam logic [2:0] F3_LW      = 3'b010;
  localparam logic [2:0] F3_LD      = 3'b011;
  localparam logic [2:0] F3_LBU     = 3'b100;
  localparam logic [2:0] F3_LHU     = 3'b101;
  localparam logic [2:0] F3_LWU     = 3'b110;
  localparam logic [2:0] F3_BR_R2   = 3'b010;  // reserved branch func3
  localparam logic [2:0] F3_BR_R3   = 3'b011;  // reserved branch func3
  localparam logic [2:0] F3_JALR    = 3'b000;

  // mem_size encodings
  localparam logic [1:0] MEM_B = 2'd0;
  localparam logic [1:0] MEM_H = 2'd1;
  localparam logic [1:0] MEM_W = 2'd2;
  localparam logic [1:0] MEM_D = 2'd3;

  typedef struct packed {
    logic [31:0]         inst;
    logic [MAX_XLEN-1:0] pc;
    logic [MAX_XLEN-1:0] op1;
    logic [MAX_XLEN-1:0] op2;
    logic [MAX_XLEN-1:0] base;
    logic [MAX_XLEN-1:0] offset;
    logic [4:0]          rd;
    logic                reg_wen;
    logic                mem_ren;
    logic                mem_wen;
    logic [1:0]          mem_size;
    logic                mem_unsigned;
    logic                word_op;
`ifdef ID_ILLEGAL_TRAP_EN
    logic                illegal;
`endif
  } id_bundle_t;

endpackage

// File: rtl/id_stage_pipe_if.sv
// Decode-to-execute channel: registered bundle plus valid/ready handshake.
// master = decode stage (producer), slave = execute stage (consumer).
// illegal_o exists only when ID_ILLEGAL_TRAP_EN is defined.
interface id_stage_pipe_if #(
  parameter int XLEN = 64
) ();
  logic            out_valid;
  logic            out_ready;
  logic [31:0]     inst_o;
  logic [XLEN-1:0] inst_addr_o;
  logic [XLEN-1:0] op1_o;
  logic [XLEN-1:0] op2_o;
  logic [4:0]      rd_addr_o;
  logic            reg_wen_o;
  logic [XLEN-1:0] base_addr_o;
  logic [XLEN-1:0] offset_addr_o;
  logic            mem_ren_o;
  logic            mem_wen_o;
  logic [1:0]      mem_size_o;
  logic            mem_unsigned_o;
  logic            word_op_o;
`ifdef ID_ILLEGAL_TRAP_EN
  logic            illegal_o;
`endif

  modport master (
    input  out_ready,
`ifdef ID_ILLEGAL_TRAP_EN
    output illegal_o,
`endif
    output out_valid, inst_o, inst_addr_o, op1_o, op2_o, rd_addr_o, reg_wen_o,
           base_addr_o, offset_addr_o, mem_ren_o, mem_wen_o, mem_size_o,
           mem_unsigned_o, word_op_o
  );

  modport slave (
    output out_ready,
`ifdef ID_ILLEGAL_TRAP_EN
    input  illegal_o,
`endif
    input  out_valid, inst_o, inst_addr_o, op1_o, op2_o, rd_addr_o, reg_wen_o,
           base_addr_o, offset_addr_o, mem_ren_o, mem_wen_o, mem_size_o,
           mem_unsigned_o, word_op_o
  );
endinterface

// File: rtl/id_decode.sv
// Combinational RV32I/RV64I decoder: instruction, PC and register data in,
// decoded bundle and rs1/rs2 usage flags out. Undecodable instructions give
// an all-zero bundle (with ID_ILLEGAL_TRAP_EN: inst/pc kept, illegal set).
module id_decode
  import id_pkg::*;
#(
  parameter int XLEN = 64,
  parameter int SHW  = $clog2(XLEN)
) (
  input  logic [31:0]     inst,
  input  logic [XLEN-1:0] pc,
  input  logic [XLEN-1:0] rs1_data,
  input  logic [XLEN-1:0] rs2_data,
  output id_bundle_t      bundle,
  output logic            rs1_used,
  output logic            rs2_used
);
  localparam bit IS_RV64 = (XLEN == 64);

  logic [6:0]          opcode;
  logic [2:0]          f3;
  logic [MAX_XLEN-1:0] pc_w, rs1_w, rs2_w, shamt_mask;
  logic [MAX_XLEN-1:0] imm_i, imm_s, imm_b, imm_u, imm_j;
  logic                is_shift;
  logic                legal;
  logic                writes_rd;
  id_bundle_t          dec;

  assign opcode     = inst[6:0];
  assign f3         = inst[14:12];
  assign pc_w       = MAX_XLEN'(pc);
  assign rs1_w      = MAX_XLEN'(rs1_data);
  assign rs2_w      = MAX_XLEN'(rs2_data);
  assign shamt_mask = (64'd1 << SHW) - 64'd1;
  assign is_shift   = (f3 == F3_SLL) || (f3 == F3_SRL_SRA);

  assign imm_i = {{52{inst[31]}}, inst[31:20]};
  assign imm_s = {{52{inst[31]}}, inst[31:25], inst[11:7]};
  assign imm_b = {{51{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
  assign imm_u = {{32{inst[31]}}, inst[31:12], 12'b0};
  assign imm_j = {{43{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};

  // rs1 is read by everything except U/J formats; rs2 only by R/S/B formats
  assign rs1_used = !((opcode == LUI) || (opcode == AUIPC) || (opcode == JAL));
  assign rs2_used = (opcode == TYPE_R_M) || (opcode == OP_32) ||
                    (opcode == STORE) || (opcode == B);

  // Per-opcode field selection, then rd/illegal post-processing
  always_comb begin
    dec       = '0;
    legal     = 1'b0;
    writes_rd = 1'b0;
    dec.inst  = inst;
    dec.pc    = pc_w;
    case (opcode)
      TYPE_I: begin
        legal     = 1'b1;
        writes_rd = 1'b1;
        dec.op1   = rs1_w;
        dec.op2   = is_shift ? MAX_XLEN'(inst[20 +: SHW]) : imm_i;
      end
      TYPE_R_M: begin
        legal     = 1'b1;
        writes_rd = 1'b1;
        dec.op1   = rs1_w;
        dec.op2   = is_shift ? (rs2_w & shamt_mask) : rs2_w;
      end
      OP_IMM_32: begin
        // shamt is 5 bits; inst[25] set would be a 6-bit shift, which is reserved
        legal       = IS_RV64 && ((f3 == F3_ADD_SUB) || (is_shift && !inst[25]));
        writes_rd   = 1'b1;
        dec.word_op = 1'b1;
        dec.op1     = rs1_w;
        dec.op2     = is_shift ? MAX_XLEN'(inst[24:20]) : imm_i;
      end
      OP_32: begin
        legal       = IS_RV64 && ((f3 == F3_ADD_SUB) || is_shift);
        writes_rd   = 1'b1;
        dec.word_op = 1'b1;
        dec.op1     = rs1_w;
        dec.op2     = is_shift ? (rs2_w & 64'h1F) : rs2_w;
      end
      LOAD: begin
        legal = (f3 == F3_LB) || (f3 == F3_LH) || (f3 == F3_LW) ||
                (f3 == F3_LBU) || (f3 == F3_LHU) ||
                (IS_RV64 && ((f3 == F3_LD) || (f3 == F3_LWU)));
        writes_rd        = 1'b1;
        dec.base         = rs1_w;
        dec.offset       = imm_i;
        dec.mem_ren      = 1'b1;
        dec.mem_size     = f3[1:0];
        dec.mem_unsigned = f3[2];
      end
      STORE: begin
        legal        = !f3[2] && (IS_RV64 || (f3[1:0] != MEM_D));
        dec.base     = rs1_w;
        dec.offset   = imm_s;
        dec.op2      = rs2_w;
        dec.mem_wen  = 1'b1;
        dec.mem_size = f3[1:0];
      end
      B: begin
        legal      = (f3 != F3_BR_R2) && (f3 != F3_BR_R3);
        dec.op1    = rs1_w;
        dec.op2    = rs2_w;
        dec.base   = pc_w;
        dec.offset = imm_b;
      end
      JAL: begin
        legal      = 1'b1;
        writes_rd  = 1'b1;
        dec.op1    = pc_w;
        dec.op2    = 64'd4;
        dec.base   = pc_w;
        dec.offset = imm_j;
      end
      JALR: begin
        legal      = (f3 == F3_JALR);
        writes_rd  = 1'b1;
        dec.op1    = pc_w;
        dec.op2    = 64'd4;
        dec.base   = rs1_w;
        dec.offset = imm_i;
      end
      LUI: begin
        legal     = 1'b1;
        writes_rd = 1'b1;
        dec.op2   = imm_u;
      end
      AUIPC: begin
        legal     = 1'b1;
        writes_rd = 1'b1;
        dec.op1   = pc_w;
        dec.op2   = imm_u;
      end
      default: ;
    endcase
    dec.rd      = writes_rd ? inst[11:7] : 5'd0;
    dec.reg_wen = writes_rd && (inst[11:7] != 5'd0);
    if (!legal) begin
      dec = '0;
`ifdef ID_ILLEGAL_TRAP_EN
      // keep inst/pc so the trap handler can report mtval/mepc
      dec.inst    = inst;
      dec.pc      = pc_w;
      dec.illegal = 1'b1;
`endif
    end
    bundle = dec;
  end

endmodule

// File: rtl/id_stage_pipe.sv
// Registered decode stage between if_id and ex: decodes one instruction per
// accept, holds it behind a valid/ready handshake, stalls on load-use
// hazards against the held instruction and drops its contents on flush.
// Optional: ID_ILLEGAL_TRAP_EN adds the registered illegal_o flag.
module id_stage_pipe
  import id_pkg::*;
#(
  parameter int XLEN = 64,
  parameter int SHW  = $clog2(XLEN)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [31:0]       inst_i,
  input  logic [XLEN-1:0]   inst_addr_i,
  output logic [4:0]        rs1_addr_o,
  output logic [4:0]        rs2_addr_o,
  input  logic [XLEN-1:0]   rs1_data_i,
  input  logic [XLEN-1:0]   rs2_data_i,
  input  logic              flush_i,
  id_stage_pipe_if.master   ex_if
);
  id_bundle_t bundle_next, bundle_reg;
  logic       valid_reg;
  logic       rs1_used, rs2_used;
  logic       hazard, accept;

  assign rs1_addr_o = inst_i[19:15];
  assign rs2_addr_o = inst_i[24:20];

  id_decode #(.XLEN(XLEN), .SHW(SHW)) u_decode (
    .inst     (inst_i),
    .pc       (inst_addr_i),
    .rs1_data (rs1_data_i),
    .rs2_data (rs2_data_i),
    .bundle   (bundle_next),
    .rs1_used (rs1_used),
    .rs2_used (rs2_used)
  );

  // A held load whose rd feeds the incoming instruction must leave first
  assign hazard = valid_reg && bundle_reg.mem_ren && (bundle_reg.rd != 5'd0) &&
                  ((rs1_used && (bundle_reg.rd == rs1_addr_o)) ||
                   (rs2_used && (bundle_reg.rd == rs2_addr_o)));
  assign in_ready = !flush_i && !hazard && (!valid_reg || ex_if.out_ready);
  assign accept   = in_valid && in_ready;

  // Output register: flush > accept > drain > hold
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_reg  <= 1'b0;
      bundle_reg <= '0;
    end else if (flush_i) begin
      valid_reg  <= 1'b0;
    end else if (accept) begin
      valid_reg  <= 1'b1;
      bundle_reg <= bundle_next;
    end else if (ex_if.out_ready) begin
      valid_reg  <= 1'b0;
    end
  end

  assign ex_if.out_valid      = valid_reg;
  assign ex_if.inst_o         = bundle_reg.inst;
  assign ex_if.inst_addr_o    = bundle_reg.pc[XLEN-1:0];
  assign ex_if.op1_o          = bundle_reg.op1[XLEN-1:0];
  assign ex_if.op2_o          = bundle_reg.op2[XLEN-1:0];
  assign ex_if.rd_addr_o      = bundle_reg.rd;
  assign ex_if.reg_wen_o      = bundle_reg.reg_wen;
  assign ex_if.base_addr_o    = bundle_reg.base[XLEN-1:0];
  assign ex_if.offset_addr_o  = bundle_reg.offset[XLEN-1:0];
  assign ex_if.mem_ren_o      = bundle_reg.mem_ren;
  assign ex_if.mem_wen_o      = bundle_reg.mem_wen;
  assign ex_if.mem_size_o     = bundle_reg.mem_size;
  assign ex_if.mem_unsigned_o = bundle_reg.mem_unsigned;
  assign ex_if.word_op_o      = bundle_reg.word_op;
`ifdef ID_ILLEGAL_TRAP_EN
  assign ex_if.illegal_o      = bundle_reg.illegal;
`endif

endmodule

// File: tb/tb_id_stage_pipe.sv
// Bench for id_stage_pipe (XLEN=64): a vector table pushed through a
// scoreboard, plus hand-written load-use, backpressure, flush and reset runs.
module tb_id_stage_pipe;
  localparam int XLEN = 64;
  localparam logic [6:0] O_OPIMM = 7'b0010011, O_OP = 7'b0110011, O_OPIMM32 = 7'b0011011;
  localparam logic [6:0] O_OP32 = 7'b0111011, O_LOAD = 7'b0000011, O_STORE = 7'b0100011;
  localparam logic [6:0] O_JALR = 7'b1100111, O_LUI = 7'b0110111, O_AUIPC = 7'b0010111;
  localparam logic [63:0] PC0 = 64'h8000_0000;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            in_valid, in_ready, flush_i;
  logic [31:0]     inst_i;
  logic [XLEN-1:0] inst_addr_i, rs1_data_i, rs2_data_i;
  logic [4:0]      rs1_addr_o, rs2_addr_o;

  id_stage_pipe_if #(.XLEN(XLEN)) ex_if ();

  id_stage_pipe #(.XLEN(XLEN)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .inst_i      (inst_i),
    .inst_addr_i (inst_addr_i),
    .rs1_addr_o  (rs1_addr_o),
    .rs2_addr_o  (rs2_addr_o),
    .rs1_data_i  (rs1_data_i),
    .rs2_data_i  (rs2_data_i),
    .flush_i     (flush_i),
    .ex_if       (ex_if)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] inst;
    logic [63:0] pc, r1, r2, op1, op2, base, off;
    logic [4:0]  rd;
    logic        wen, ren, wm;
    logic [1:0]  size;
    logic        uns, word, ill;
    logic [3:0]  chk;  // {op1, op2, base, off} compared
  } vec_t;

  vec_t vecs[$];
  vec_t sb[$];
  vec_t mon_e;
  int   tests = 0;
  int   fails = 0;

  function automatic logic [31:0] enc_i(logic [11:0] imm, logic [4:0] rs1, logic [2:0] f3,
                                        logic [4:0] rd, logic [6:0] opc);
    return {imm, rs1, f3, rd, opc};
  endfunction
  function automatic logic [31:0] enc_r(logic [6:0] f7, logic [4:0] rs2, logic [4:0] rs1,
                                        logic [2:0] f3, logic [4:0] rd, logic [6:0] opc);
    return {f7, rs2, rs1, f3, rd, opc};
  endfunction
  function automatic logic [31:0] enc_s(logic [11:0] imm, logic [4:0] rs2, logic [4:0] rs1,
                                        logic [2:0] f3);
    return {imm[11:5], rs2, rs1, f3, imm[4:0], O_STORE};
  endfunction
  function automatic logic [31:0] enc_b(logic [12:0] imm, logic [4:0] rs2, logic [4:0] rs1,
                                        logic [2:0] f3);
    return {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], 7'b1100011};
  endfunction
  function automatic logic [31:0] enc_j(logic [20:0] imm, logic [4:0] rd);
    return {imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'b1101111};
  endfunction

  function automatic vec_t mk(logic [31:0] inst, logic [63:0] pc, logic [63:0] r1, logic [63:0] r2,
                              logic [63:0] op1, logic [63:0] op2, logic [63:0] base, logic [63:0] off,
                              logic [4:0] rd, logic wen, logic ren, logic wm, logic [1:0] size,
                              logic uns, logic word, logic ill, logic [3:0] chk);
    vec_t v;
    v.inst = inst; v.pc = pc; v.r1 = r1; v.r2 = r2; v.op1 = op1; v.op2 = op2;
    v.base = base; v.off = off; v.rd = rd; v.wen = wen; v.ren = ren; v.wm = wm;
    v.size = size; v.uns = uns; v.word = word; v.ill = ill; v.chk = chk;
    return v;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Scoreboard: one popped bundle is checked per handshake transfer
  always @(negedge clk) begin
    if (rst_n && ex_if.out_valid && ex_if.out_ready) begin
      if (sb.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL sb_unexpected: got bundle inst 0x%0h, expected none", ex_if.inst_o);
      end else begin
        mon_e = sb.pop_front();
        $display("[TB] out inst=0x%08h op1=0x%0h op2=0x%0h rd=%0d", ex_if.inst_o,
                 ex_if.op1_o, ex_if.op2_o, ex_if.rd_addr_o);
        if (mon_e.chk[3]) chk("op1", ex_if.op1_o, mon_e.op1);
        if (mon_e.chk[2]) chk("op2", ex_if.op2_o, mon_e.op2);
        if (mon_e.chk[1]) chk("base", ex_if.base_addr_o, mon_e.base);
        if (mon_e.chk[0]) chk("offset", ex_if.offset_addr_o, mon_e.off);
        chk("reg_wen", 64'(ex_if.reg_wen_o), 64'(mon_e.wen));
        if (mon_e.wen) chk("rd", 64'(ex_if.rd_addr_o), 64'(mon_e.rd));
        chk("mem_ren", 64'(ex_if.mem_ren_o), 64'(mon_e.ren));
        chk("mem_wen", 64'(ex_if.mem_wen_o), 64'(mon_e.wm));
        if (mon_e.ren || mon_e.wm || mon_e.ill) chk("mem_size", 64'(ex_if.mem_size_o), 64'(mon_e.size));
        if (mon_e.ren || mon_e.ill) chk("mem_unsigned", 64'(ex_if.mem_unsigned_o), 64'(mon_e.uns));
        chk("word_op", 64'(ex_if.word_op_o), 64'(mon_e.word));
`ifdef ID_ILLEGAL_TRAP_EN
        chk("illegal", 64'(ex_if.illegal_o), 64'(mon_e.ill));
        chk("inst", 64'(ex_if.inst_o), 64'(mon_e.inst));
        chk("pc", ex_if.inst_addr_o, mon_e.pc);
`else
        if (!mon_e.ill) begin
          chk("inst", 64'(ex_if.inst_o), 64'(mon_e.inst));
          chk("pc", ex_if.inst_addr_o, mon_e.pc);
        end
`endif
      end
    end
  end

  task automatic drive(input logic [31:0] inst, input logic [63:0] pc,
                       input logic [63:0] r1, input logic [63:0] r2);
    in_valid = 1'b1; inst_i = inst; inst_addr_i = pc; rs1_data_i = r1; rs2_data_i = r2;
  endtask

  // Present a vector until accepted (bounded), pushing its expectation on accept
  task automatic send(input vec_t v);
    bit done = 0;
    drive(v.inst, v.pc, v.r1, v.r2);
    for (int k = 0; k < 20 && !done; k++) begin
      @(negedge clk);
      if (in_ready) begin
        chk("rs1_addr", 64'(rs1_addr_o), 64'(v.inst[19:15]));
        chk("rs2_addr", 64'(rs2_addr_o), 64'(v.inst[24:20]));
        sb.push_back(v);
        done = 1;
      end
      @(posedge clk); #1;
    end
    if (!done) begin
      tests++;
      fails++;
      $display("FAIL send_timeout: inst 0x%08h never accepted, expected accept", v.inst);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t v;
    rst_n = 1'b0; in_valid = 1'b0; flush_i = 1'b0; ex_if.out_ready = 1'b1;
    inst_i = '0; inst_addr_i = '0; rs1_data_i = '0; rs2_data_i = '0;

    // table: inst, pc, r1, r2, op1, op2, base, off, rd, wen, ren, wm, size, uns, word, ill, chk
    vecs.push_back(mk(enc_i(12'hFFB, 5'd0, 3'd0, 5'd1, O_OPIMM), PC0, 0, 0, 0, 64'hFFFF_FFFF_FFFF_FFFB, 0, 0, 5'd1, 1, 0, 0, 2'd0, 0, 0, 0, 4'b1100));
    vecs.push_back(mk(enc_i(12'd40, 5'd3, 3'd1, 5'd2, O_OPIMM), PC0, 64'h1234, 0, 64'h1234, 64'd40, 0, 0, 5'd2, 1, 0, 0, 2'd0, 0, 0, 0, 4'b1100));
    vecs.push_back(mk(enc_i(12'h403, 5'd5, 3'd5, 5'd4, O_OPIMM), PC0, 64'hF0, 0, 64'hF0, 64'd3, 0, 0, 5'd4, 1, 0, 0, 2'd0, 0, 0, 0, 4'b1100));
    vecs.push_back(mk(enc_r(7'd0, 5'd8, 5'd7, 3'd0, 5'd6, O_OP), PC0, 64'h11, 64'h22, 64'h11, 64'h22, 0, 0, 5'd6, 1, 0, 0, 2'd0, 0, 0, 0, 4'b1100));
    vecs.push_back(mk(enc_r(7'd0, 5'd2, 5'd1, 3'd1, 5'd9, O_OP), PC0, 64'h5, 64'h7F, 64'h5, 64'h3F, 0, 0, 5'd9, 1, 0, 0, 2'd0, 0, 0, 0, 4'b1100));
    vecs.push_back(mk(enc_r(7'd0, 5'd2, 5'd1, 3'd1, 5'd10, O_OP32), PC0, 64'h5, 64'h7F, 64'h5, 64'h1F, 0, 0, 5'd10, 1, 0, 0, 2'd0, 0, 1, 0, 4'b1100));
    vecs.push_back(mk(enc_i(12'hFFF, 5'd1, 3'd0, 5'd11, O_OPIMM32), PC0, 64'h7FFF_FFFF, 0, 64'h7FFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 0, 0, 5'd11, 1, 0, 0, 2'd0, 0, 1, 0, 4'b1100));
    vecs.push_back(mk(enc_i(12'hFFC, 5'd3, 3'd2, 5'd12, O_LOAD), PC0, 64'h2000, 0, 0, 0, 64'h2000, 64'hFFFF_FFFF_FFFF_FFFC, 5'd12, 1, 1, 0, 2'd2, 0, 0, 0, 4'b0011));
    vecs.push_back(mk(enc_i(12'h001, 5'd3, 3'd4, 5'd13, O_LOAD), PC0, 64'h3000, 0, 0, 0, 64'h3000, 64'd1, 5'd13, 1, 1, 0, 2'd0, 1, 0, 0, 4'b0011));
    vecs.push_back(mk(enc_s(12'd16, 5'd4, 5'd5, 3'd3), PC0, 64'h4000, 64'hDEAD, 0, 64'hDEAD, 64'h4000, 64'd16, 5'd0, 0, 0, 1, 2'd3, 0, 0, 0, 4'b0111));
    vecs.push_back(mk(enc_b(13'h1FF8, 5'd2, 5'd1, 3'd0), PC0 + 64'h100, 64'h7, 64'h7, 64'h7, 64'h7, PC0 + 64'h100, 64'hFFFF_FFFF_FFFF_FFF8, 5'd0, 0, 0, 0, 2'd0, 0, 0, 0, 4'b1111));
    vecs.push_back(mk(enc_j(21'h000800, 5'd1), PC0 + 64'h200, 0, 0, PC0 + 64'h200, 64'd4, PC0 + 64'h200, 64'h800, 5'd1, 1, 0, 0, 2'd0, 0, 0, 0, 4'b1111));
    vecs.push_back(mk(enc_i(12'd12, 5'd1, 3'd0, 5'd0, O_JALR), PC0 + 64'h300, 64'h9000, 0, PC0 + 64'h300, 64'd4, 64'h9000, 64'd12, 5'd0, 0, 0, 0, 2'd0, 0, 0, 0, 4'b1111));
    vecs.push_back(mk({20'h80000, 5'd5, O_LUI}, PC0, 0, 0, 0, 64'hFFFF_FFFF_8000_0000, 0, 0, 5'd5, 1, 0, 0, 2'd0, 0, 0, 0, 4'b1100));
    vecs.push_back(mk({20'h00001, 5'd6, O_AUIPC}, PC0 + 64'h400, 0, 0, PC0 + 64'h400, 64'h1000, 0, 0, 5'd6, 1, 0, 0, 2'd0, 0, 0, 0, 4'b1100));
    vecs.push_back(mk(enc_i(12'h021, 5'd1, 3'd1, 5'd7, O_OPIMM32), PC0 + 64'h500, 64'h77, 0, 0, 0, 0, 0, 5'd0, 0, 0, 0, 2'd0, 0, 0, 1, 4'b1111));
    vecs.push_back(mk(32'h0000_037F, PC0 + 64'h504, 64'h77, 64'h66, 0, 0, 0, 0, 5'd0, 0, 0, 0, 2'd0, 0, 0, 1, 4'b1111));
    vecs.push_back(mk(enc_i(12'd0, 5'd2, 3'd3, 5'd8, O_LOAD), PC0, 64'h5000, 0, 0, 0, 64'h5000, 64'd0, 5'd8, 1, 1, 0, 2'd3, 0, 0, 0, 4'b0011));
    vecs.push_back(mk(enc_i(12'h005, 5'd1, 3'd1, 5'd7, O_OPIMM32), PC0, 64'h9, 0, 64'h9, 64'd5, 0, 0, 5'd7, 1, 0, 0, 2'd0, 0, 1, 0, 4'b1100));

    #23 rst_n = 1'b1;
    @(posedge clk); #1;
    chk("reset_out_valid", 64'(ex_if.out_valid), 64'd0);
    chk("reset_op2", ex_if.op2_o, 64'd0);
    chk("reset_reg_wen", 64'(ex_if.reg_wen_o), 64'd0);
    chk("reset_in_ready", 64'(in_ready), 64'd1);

    // table vectors, back-to-back with out_ready=1
    for (int i = 0; i < vecs.size(); i++) begin
      $display("[TB] vec %0d inst=0x%08h", i, vecs[i].inst);
      send(vecs[i]);
    end
    in_valid = 1'b0;
    repeat (3) begin @(posedge clk); #1; end

    // load-use: LD x5 then ADD x6,x5,x3 -> one stall, one bubble
    $display("[TB] seq load_use");
    send(mk(enc_i(12'd8, 5'd2, 3'd3, 5'd5, O_LOAD), PC0, 64'h100, 0, 0, 0, 64'h100, 64'd8, 5'd5, 1, 1, 0, 2'd3, 0, 0, 0, 4'b0011));
    drive(enc_r(7'd0, 5'd3, 5'd5, 3'd0, 5'd6, O_OP), PC0 + 64'h4, 64'h55, 64'h33);
    @(negedge clk);
    chk("lu_stall_in_ready", 64'(in_ready), 64'd0);
    chk("lu_ld_valid", 64'(ex_if.out_valid), 64'd1);
    @(posedge clk); #1;
    @(negedge clk);
    chk("lu_bubble", 64'(ex_if.out_valid), 64'd0);
    chk("lu_resume_in_ready", 64'(in_ready), 64'd1);
    sb.push_back(mk(enc_r(7'd0, 5'd3, 5'd5, 3'd0, 5'd6, O_OP), PC0 + 64'h4, 64'h55, 64'h33, 64'h55, 64'h33, 0, 0, 5'd6, 1, 0, 0, 2'd0, 0, 0, 0, 4'b1100));
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("lu_add_valid", 64'(ex_if.out_valid), 64'd1);
    chk("lu_add_rd", 64'(ex_if.rd_addr_o), 64'd6);
    repeat (2) begin @(posedge clk); #1; end

    // backpressure: held bundle stays put for 3 cycles, then next is taken at release
    $display("[TB] seq backpressure");
    ex_if.out_ready = 1'b0;
    drive(enc_i(12'd7, 5'd0, 3'd0, 5'd1, O_OPIMM), PC0, 0, 0);
    @(negedge clk);
    chk("bp_first_in_ready", 64'(in_ready), 64'd1);
    sb.push_back(mk(enc_i(12'd7, 5'd0, 3'd0, 5'd1, O_OPIMM), PC0, 0, 0, 0, 64'd7, 0, 0, 5'd1, 1, 0, 0, 2'd0, 0, 0, 0, 4'b1100));
    @(posedge clk); #1;
    drive(enc_i(12'd9, 5'd0, 3'd0, 5'd2, O_OPIMM), PC0 + 64'h4, 0, 0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("bp_hold_in_ready", 64'(in_ready), 64'd0);
      chk("bp_hold_valid", 64'(ex_if.out_valid), 64'd1);
      chk("bp_hold_op2", ex_if.op2_o, 64'd7);
      @(posedge clk); #1;
    end
    ex_if.out_ready = 1'b1;
    @(negedge clk);
    chk("bp_release_in_ready", 64'(in_ready), 64'd1);
    sb.push_back(mk(enc_i(12'd9, 5'd0, 3'd0, 5'd2, O_OPIMM), PC0 + 64'h4, 0, 0, 0, 64'd9, 0, 0, 5'd2, 1, 0, 0, 2'd0, 0, 0, 0, 4'b1100));
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("bp_second_op2", ex_if.op2_o, 64'd9);
    repeat (2) begin @(posedge clk); #1; end

    // flush with both a held and an incoming instruction
    $display("[TB] seq flush");
    ex_if.out_ready = 1'b0;
    drive(enc_i(12'd3, 5'd0, 3'd0, 5'd3, O_OPIMM), PC0, 0, 0);
    @(negedge clk);
    chk("fl_setup_in_ready", 64'(in_ready), 64'd1);
    @(posedge clk); #1;
    drive(enc_i(12'd4, 5'd0, 3'd0, 5'd4, O_OPIMM), PC0 + 64'h4, 0, 0);
    flush_i = 1'b1;
    @(negedge clk);
    chk("fl_in_ready", 64'(in_ready), 64'd0);
    chk("fl_held_valid", 64'(ex_if.out_valid), 64'd1);
    @(posedge clk); #1;
    flush_i = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    chk("fl_killed", 64'(ex_if.out_valid), 64'd0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("fl_not_accepted", 64'(ex_if.out_valid), 64'd0);
    @(posedge clk); #1;
    ex_if.out_ready = 1'b1;

    // asynchronous reset while a bundle is held
    $display("[TB] seq async_reset");
    ex_if.out_ready = 1'b0;
    drive(enc_i(12'hFFB, 5'd0, 3'd0, 5'd1, O_OPIMM), PC0, 0, 0);
    @(negedge clk);
    chk("rst_setup_in_ready", 64'(in_ready), 64'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("rst_held_valid", 64'(ex_if.out_valid), 64'd1);
    @(posedge clk); #3;
    rst_n = 1'b0;
    #1;
    chk("rst_out_valid", 64'(ex_if.out_valid), 64'd0);
    chk("rst_op2", ex_if.op2_o, 64'd0);
    chk("rst_rd", 64'(ex_if.rd_addr_o), 64'd0);
    chk("rst_reg_wen", 64'(ex_if.reg_wen_o), 64'd0);
    chk("rst_inst", 64'(ex_if.inst_o), 64'd0);
    chk("rst_pc", ex_if.inst_addr_o, 64'd0);
    @(negedge clk); #1;
    rst_n = 1'b1;
    ex_if.out_ready = 1'b1;
    @(posedge clk); #1;
    chk("rst_after_valid", 64'(ex_if.out_valid), 64'd0);

    chk("sb_drained", 64'(sb.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
